// File: rtl/dff.sv
// Parameterised D flip-flop with synchronous active-high reset and optional clock enable.
// One port list serves both the free-running and the enable-gated configurations.
module dff #(
    parameter bit               USE_EN      = 1'b1,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    generate
        if (USE_EN) begin : g_enabled
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            always_ff @(posedge clk) begin
                if (rst)
                    q <= RESET_VALUE;
                else if (en)
                    q <= d;
            end
        end else begin : g_free_running
            // en is kept on the port list but has no function in this configuration.
            logic unused_en;
            assign unused_en = en;

            always_ff @(posedge clk) begin
                if (rst)
                    q <= RESET_VALUE;
                else
                    q <= d;
            end
        end
    endgenerate

endmodule

// File: tb/tb_dff.sv
// Scoreboard bench for dff: three instances (default, free-running, 8-bit with A5 reset).
// Stimulus pushes the expected q for the coming edge; a monitor pops and compares on falling edges.
`timescale 1ns/1ps
module tb_dff;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       en_b;
    logic       d;
    logic [7:0] d8;
    logic       q_a;
    logic       q_b;
    logic [7:0] q_c;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #1 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dff u_a (
        .clk(clk), .rst(rst), .d(d), .en(en), .q(q_a)
    );

    dff #(.USE_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .d(d), .en(en_b), .q(q_b)
    );

    dff #(.USE_EN(1'b1), .WIDTH(8), .RESET_VALUE(8'hA5)) u_c (
        .clk(clk), .rst(rst), .d(d8), .en(en), .q(q_c)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every expectation that has come due at this falling edge.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                case (e.sel)
                    0:       act = {7'b0, q_a};
                    1:       act = {7'b0, q_b};
                    default: act = q_c;
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    // Drive inputs on a falling edge and record what each instance must show after the next rising edge.
    task automatic step(input logic r, input logic e, input logic dv, input logic [7:0] d8v,
                        input logic xa, input logic xb, input logic [7:0] xc,
                        input string name, input bit pulse = 1'b0);
        exp_t ent;
        @(negedge clk);
        rst = r;
        en  = e;
        d   = dv;
        d8  = d8v;
        ent.due = cyc + 1;
        ent.sel = 0; ent.exp = {7'b0, xa}; ent.name = {name, "_a"}; sb.push_back(ent);
        ent.sel = 1; ent.exp = {7'b0, xb}; ent.name = {name, "_b"}; sb.push_back(ent);
        ent.sel = 2; ent.exp = xc;         ent.name = {name, "_c"}; sb.push_back(ent);
        if (pulse) begin
            #0.3 rst = 1'b1;
            #0.4 rst = 1'b0;
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        en_b = 1'b0;
        d    = 1'b0;
        d8   = 8'h00;

        //    rst   en    d     d8     q_a   q_b   q_c
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, "reset");
        step(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, "cap1");
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, "cap0");
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h3C, "hold0_d1");
        step(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h3C, "hold0_d0");

        en_b = 1'bx;
        step(1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, "load1");
        step(1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h11, "hold1_t0");
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h11, "hold1_t1");
        step(1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h11, "hold1_t2");
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h11, "hold1_t3");

        step(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'hA5, "rst_wins");
        step(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, "resume");
        step(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, "rst_glitch", 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h96, 1'b1, 1'b1, 8'h96, "preload");
        step(1'b1, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 8'hA5, "rst_hold0");
        step(1'b1, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 8'hA5, "rst_hold1");
        step(1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 8'h81, "post_rst");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff.md
# dff

Parameterised D flip-flop with synchronous, active-high reset and an optional clock-enable. It is the basic storage primitive for registering single-bit or multi-bit control and data signals. A parameter selects between a free-running register and an enable-gated register, so one module covers both uses.

## Interface

Parameters:
- USE_EN, default 1: 1 means `en` gates the capture of `d`; 0 means `en` is ignored and `d` is captured on every clock edge.
- WIDTH, default 1: bit width of `d` and `q`; legal range 1 and up.
- RESET_VALUE, default 0: value loaded into `q` on reset, WIDTH bits wide.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  WIDTH  data to capture.
- en  input  1  capture enable, active-high; used only when USE_EN=1.
- q  output  WIDTH  registered output, driven directly from the storage flop with no combinational path from any input.

## Operation

- Evaluated on each rising edge of `clk`, in strict priority order:
  1. `rst`=1: `q` <= RESET_VALUE. This applies regardless of `en` and `d`.
  2. Otherwise, if USE_EN=0: `q` <= `d`.
  3. Otherwise, if USE_EN=1 and `en`=1: `q` <= `d`.
  4. Otherwise, if USE_EN=1 and `en`=0: `q` holds its previous value.
- Reset is synchronous only:
  - Asserting `rst` between clock edges has no effect until the next rising edge.
  - Deasserting `rst` takes effect at the first rising edge where it is sampled low.
- Before the first rising edge with `rst`=1, `q` is undefined. The system must apply reset before relying on `q`.
- When USE_EN=0:
  - The `en` input must still exist, so one port list serves both configurations.
  - `en` must have no functional effect and must not be required to be driven to a known value.
- X/Z handling:
  - With USE_EN=1, an X on `en` with `rst`=0 may produce X on `q`.
  - With `rst`=1, `q` must become RESET_VALUE regardless of X on `d` or `en`.
- All WIDTH bits are captured, held and reset together. There is no per-bit enable.

## Timing

- Capture latency is one clock: a value on `d` sampled at rising edge N appears on `q` after edge N. It is stable by the following falling edge and stays until at least edge N+1.
- Reset latency is one clock: with `rst`=1 sampled at edge N, `q`=RESET_VALUE after edge N.
- Hold behaviour: with USE_EN=1 and `en`=0, `q` is unchanged across any number of edges, whatever `d` does.
- Simultaneous `rst`=1 and `en`=1: reset wins and `q`=RESET_VALUE.
- Reset asserted while `en`=1 and `d` toggles: `q` = RESET_VALUE for every edge at which `rst`=1. Normal capture resumes at the first edge with `rst`=0.
- Inputs must meet setup and hold relative to the rising edge. The bench drives inputs and checks `q` on the falling edge.

## Test plan

Default parameters (USE_EN=1, WIDTH=1, RESET_VALUE=0), clock period 2 time units:
- `rst`=1, `en`=0, `d`=0 for one edge -> `q`=0 at the next falling edge.
- `rst`=0, `en`=1, `d`=1 -> `q`=1 after one edge. Then `d`=0 -> `q`=0 after one edge.
- `en`=0 with `q`=0, then `d`=1 for one edge -> `q` stays 0. Then `d`=0 -> `q`=0.
- `en`=0 with `q`=1 (loaded earlier), `d` toggling 0/1 for 4 edges -> `q` stays 1 throughout.
- `rst`=1 together with `en`=1, `d`=1 -> `q`=0. `rst` pulsed between edges but low at every rising edge -> `q` unaffected.

Other configurations:
- USE_EN=0, `en` held at 0 or X, `d` sequence 1,0,1 -> `q` follows as 1,0,1, each one edge late.
- WIDTH=8, RESET_VALUE=8'hA5:
  - reset -> `q`=8'hA5.
  - `en`=1, `d`=8'h3C -> `q`=8'h3C.
  - `en`=0, `d`=8'hFF -> `q`=8'h3C.
